avg_pool_stream: RTL and testbench

Streaming, parametrised 2-D pooling engine that replaces the fixed 28x28, 2x2, address-driven average pooling front end of the digit-recognition network. It accepts pixels one per handshake in raster order and emits pooled values in raster order over a valid/ready interface. A per-column accumulator line buffer means the full image array is never held. It sits between the image source and `dense_layer1`'s input buffer, and its frame-done pulse starts the hidden layer.

---
 rtl/nn_pkg.sv | 40 ++++
 rtl/avg_pool_stream_if.sv | 23 ++
 rtl/pool_line_acc.sv | 42 ++++
 rtl/avg_pool_stream.sv | 158 +++++++++++++++
 tb/tb_avg_pool_stream.sv | 271 +++++++++++++++++++++++++++
 5 files changed

// File: rtl/nn_pkg.sv
// Shared types and width helpers for the pooling front end and its neighbours.
// Optional max-pool support is enabled by defining AVG_POOL_MAX_EN.
package nn_pkg;

    typedef enum logic {
        POOL_AVG = 1'b0,
        POOL_MAX = 1'b1
    } pool_mode_e;

    typedef enum logic [1:0] {
        ACC_LOAD = 2'd0,
        ACC_ADD  = 2'd1,
        ACC_MAX  = 2'd2
    } acc_op_e;

    localparam int DEF_PIX_W = 8;
    localparam int DEF_OUT_W = 16;
    localparam int DEF_POOL  = 2;
    localparam int DEF_IMG_W = 28;

    typedef logic [DEF_PIX_W-1:0] pix_t;
    typedef logic [DEF_OUT_W-1:0] out_t;

    // Index width that never collapses to zero bits for single-entry ranges.
    function automatic int width_of(input int n);
        return (n <= 32'sd1) ? 32'sd1 : $clog2(n);
    endfunction

    function automatic int acc_width(input int pix_w, input int pool);
        return pix_w + 32'sd2 * $clog2(pool);
    endfunction

    function automatic bit is_pow2(input int n);
        return (n > 32'sd0) && ((n & (n - 32'sd1)) == 32'sd0);
    endfunction

    localparam int ACC_W = acc_width(DEF_PIX_W, DEF_POOL);
    localparam int COL_W = width_of(DEF_IMG_W);

endpackage

// File: rtl/avg_pool_stream_if.sv
// Pixel-in / pooled-value-out streaming handshake bundle.
interface avg_pool_stream_if #(
    parameter int PIX_W = 8,
    parameter int OUT_W = 16
);
    logic             in_valid;
    logic             in_ready;
    logic [PIX_W-1:0] in_pixel;
    logic             out_valid;
    logic             out_ready;
    logic [OUT_W-1:0] out_data;
    logic             out_last;

    modport master (
        output in_valid, in_pixel, out_ready,
        input  in_ready, out_valid, out_data, out_last
    );

    modport slave (
        input  in_valid, in_pixel, out_ready,
        output in_ready, out_valid, out_data, out_last
    );
endinterface

// File: rtl/pool_line_acc.sv
// Per-column window accumulator line: one entry per pooled column, updated by
// read-modify-write (overwrite, add or max). Contents need no reset.
module pool_line_acc
    import nn_pkg::*;
#(
    parameter int ENTRIES = 14,
    parameter int IDX_W   = 4,
    parameter int PIX_W   = 8,
    parameter int ACC_W   = 10
) (
    input  logic             clk,
    input  logic             en_i,
    input  logic [IDX_W-1:0] idx_i,
    input  acc_op_e          op_i,
    input  logic [PIX_W-1:0] pix_i,
    output logic [ACC_W-1:0] acc_o
);

    logic [ACC_W-1:0] mem_q [ENTRIES];
    logic [ACC_W-1:0] rd_s;
    logic [ACC_W-1:0] pix_s;

    // Updated entry value; also feeds the window result in the top.
    always_comb begin
        rd_s  = mem_q[idx_i];
        pix_s = ACC_W'(pix_i);
        case (op_i)
            ACC_LOAD: acc_o = pix_s;
            ACC_ADD:  acc_o = rd_s + pix_s;
            ACC_MAX:  acc_o = (rd_s > pix_s) ? rd_s : pix_s;
            default:  acc_o = pix_s;
        endcase
    end

    // Entry write-back on every accepted pixel.
    always_ff @(posedge clk) begin
        if (en_i) begin
            mem_q[idx_i] <= acc_o;
        end
    end

endmodule

// File: rtl/avg_pool_stream.sv
// Streaming POOLxPOOL average pooling over a raster pixel stream with a one-entry
// output skid. Defining AVG_POOL_MAX_EN adds the pool_max input for max pooling.
module avg_pool_stream
    import nn_pkg::*;
#(
    parameter int IMG_W = 28,
    parameter int IMG_H = 28,
    parameter int POOL  = 2,
    parameter int PIX_W = 8,
    parameter int OUT_W = 16
) (
    input  logic                clk,
    input  logic                reset_n,
    input  logic                clear,
`ifdef AVG_POOL_MAX_EN
    input  logic                pool_max,
`endif
    avg_pool_stream_if.slave    s,
    output logic                frame_done
);

    localparam int LOG_P    = $clog2(POOL);
    localparam int SHIFT    = 2 * LOG_P;
    localparam int ACC_BITS = acc_width(PIX_W, POOL);
    localparam int COL_BITS = width_of(IMG_W);
    localparam int ROW_BITS = width_of(IMG_H);
    localparam int ENTRIES  = IMG_W / POOL;
    localparam int IDX_BITS = width_of(ENTRIES);

    generate
        if ((IMG_W % POOL) != 0 || (IMG_H % POOL) != 0 || !is_pow2(POOL) ||
            POOL < 2 || POOL > 8 || OUT_W < PIX_W) begin : g_bad_cfg
            $error("avg_pool_stream: illegal IMG_W/IMG_H/POOL/OUT_W combination");
        end
    endgenerate

    logic [COL_BITS-1:0] col_q, col_d;
    logic [ROW_BITS-1:0] row_q, row_d;
    logic                out_valid_q, out_valid_d;
    logic [OUT_W-1:0]    out_data_q, out_data_d;
    logic                out_last_q, out_last_d;
    logic                frame_done_q, frame_done_d;

    logic                hs_s, first_s, done_s, eol_s, eof_s;
    pool_mode_e          mode_s;
    acc_op_e             op_s;
    logic [ACC_BITS-1:0] acc_nxt_s;
    logic [PIX_W-1:0]    res_s;

    assign s.in_ready = !out_valid_q || s.out_ready;
    assign hs_s       = s.in_valid && s.in_ready;
    // Window position is the low bits of col/row because POOL is a power of two.
    assign first_s    = (col_q[LOG_P-1:0] == '0) && (row_q[LOG_P-1:0] == '0);
    assign done_s     = (col_q[LOG_P-1:0] == '1) && (row_q[LOG_P-1:0] == '1);
    assign eol_s      = (col_q == COL_BITS'(IMG_W - 1));
    assign eof_s      = eol_s && (row_q == ROW_BITS'(IMG_H - 1));

    // Pooling mode and accumulator operation for the current pixel.
    always_comb begin
`ifdef AVG_POOL_MAX_EN
        mode_s = pool_max ? POOL_MAX : POOL_AVG;
`else
        mode_s = POOL_AVG;
`endif
        if (first_s) begin
            op_s = ACC_LOAD;
        end else if (mode_s == POOL_MAX) begin
            op_s = ACC_MAX;
        end else begin
            op_s = ACC_ADD;
        end
        if (mode_s == POOL_MAX) begin
            res_s = acc_nxt_s[PIX_W-1:0];
        end else begin
            res_s = acc_nxt_s[ACC_BITS-1:SHIFT];
        end
    end

    pool_line_acc #(
        .ENTRIES (ENTRIES),
        .IDX_W   (IDX_BITS),
        .PIX_W   (PIX_W),
        .ACC_W   (ACC_BITS)
    ) u_line (
        .clk   (clk),
        .en_i  (hs_s && !clear),
        .idx_i (IDX_BITS'(col_q >> LOG_P)),
        .op_i  (op_s),
        .pix_i (s.in_pixel),
        .acc_o (acc_nxt_s)
    );

    // Counters, output skid register and frame-done pulse next state.
    always_comb begin
        col_d        = col_q;
        row_d        = row_q;
        out_valid_d  = out_valid_q;
        out_data_d   = out_data_q;
        out_last_d   = out_last_q;
        frame_done_d = out_valid_q && s.out_ready && out_last_q;
        if (clear) begin
            col_d        = '0;
            row_d        = '0;
            out_valid_d  = 1'b0;
            out_last_d   = 1'b0;
            frame_done_d = 1'b0;
        end else begin
            if (out_valid_q && s.out_ready) begin
                out_valid_d = 1'b0;
                out_last_d  = 1'b0;
            end else begin
                out_valid_d = out_valid_q;
            end
            if (hs_s) begin
                if (eol_s) begin
                    col_d = '0;
                    row_d = eof_s ? '0 : row_q + ROW_BITS'(1);
                end else begin
                    col_d = col_q + COL_BITS'(1);
                end
                if (done_s) begin
                    out_valid_d = 1'b1;
                    out_data_d  = OUT_W'(res_s);
                    out_last_d  = eof_s;
                end else begin
                    out_data_d = out_data_q;
                end
            end else begin
                col_d = col_q;
            end
        end
    end

    // State registers.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            col_q        <= '0;
            row_q        <= '0;
            out_valid_q  <= 1'b0;
            out_data_q   <= '0;
            out_last_q   <= 1'b0;
            frame_done_q <= 1'b0;
        end else begin
            col_q        <= col_d;
            row_q        <= row_d;
            out_valid_q  <= out_valid_d;
            out_data_q   <= out_data_d;
            out_last_q   <= out_last_d;
            frame_done_q <= frame_done_d;
        end
    end

    assign s.out_valid = out_valid_q;
    assign s.out_data  = out_data_q;
    assign s.out_last  = out_last_q;
    assign frame_done  = frame_done_q;

endmodule

// File: tb/tb_avg_pool_stream.sv
// Directed bench for avg_pool_stream: 4x4/POOL2, 28x28 default and 8x8/POOL4 instances.
module tb_avg_pool_stream;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic reset_n;
    logic clear4, clear28, clear8;
    logic fd4, fd28, fd8;
`ifdef AVG_POOL_MAX_EN
    logic pool_max;
    logic pm_off;
`endif

    avg_pool_stream_if #(.PIX_W(8), .OUT_W(16)) a4 ();
    avg_pool_stream_if #(.PIX_W(8), .OUT_W(16)) a28 ();
    avg_pool_stream_if #(.PIX_W(8), .OUT_W(16)) a8 ();

    avg_pool_stream #(.IMG_W(4), .IMG_H(4), .POOL(2), .PIX_W(8), .OUT_W(16)) u4 (
        .clk(clk), .reset_n(reset_n), .clear(clear4),
`ifdef AVG_POOL_MAX_EN
        .pool_max(pool_max),
`endif
        .s(a4), .frame_done(fd4));

    avg_pool_stream #(.IMG_W(28), .IMG_H(28), .POOL(2), .PIX_W(8), .OUT_W(16)) u28 (
        .clk(clk), .reset_n(reset_n), .clear(clear28),
`ifdef AVG_POOL_MAX_EN
        .pool_max(pm_off),
`endif
        .s(a28), .frame_done(fd28));

    avg_pool_stream #(.IMG_W(8), .IMG_H(8), .POOL(4), .PIX_W(8), .OUT_W(16)) u8 (
        .clk(clk), .reset_n(reset_n), .clear(clear8),
`ifdef AVG_POOL_MAX_EN
        .pool_max(pm_off),
`endif
        .s(a8), .frame_done(fd8));

    int n_checks = 0;
    int n_fail   = 0;
    int fd4_cnt  = 0;
    int fd28_cnt = 0;
    int fd8_cnt  = 0;
    int stall28  = 0;
    logic [16:0] q4[$];
    logic [16:0] q28[$];
    logic [16:0] q8[$];

    logic        fd4_exp;
    logic        held4_v;
    logic [15:0] held4_d;
    logic        held4_l;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    // 4x4 monitor: collects outputs, checks skid stability and frame_done timing.
    always @(negedge clk) begin
        if (!reset_n) begin
            fd4_exp <= 1'b0;
            held4_v <= 1'b0;
        end else begin
            check_eq("fd4_pulse", 32'(fd4), 32'(fd4_exp));
            if (fd4) fd4_cnt++;
            fd4_exp <= a4.out_valid && a4.out_ready && a4.out_last;
            if (held4_v) begin
                check_eq("hold_valid", 32'(a4.out_valid), 32'd1);
                check_eq("hold_data", 32'(a4.out_data), 32'(held4_d));
                check_eq("hold_last", 32'(a4.out_last), 32'(held4_l));
            end
            if (a4.out_valid && a4.out_ready) q4.push_back({a4.out_last, a4.out_data});
            if (a4.out_valid && !a4.out_ready) begin
                check_eq("hold_in_ready", 32'(a4.in_ready), 32'd0);
                held4_v <= 1'b1;
                held4_d <= a4.out_data;
                held4_l <= a4.out_last;
            end else begin
                held4_v <= 1'b0;
            end
        end
    end

    // Collectors for the 28x28 and 8x8 instances.
    always @(negedge clk) begin
        if (reset_n) begin
            if (a28.out_valid && a28.out_ready) q28.push_back({a28.out_last, a28.out_data});
            if (a8.out_valid && a8.out_ready) q8.push_back({a8.out_last, a8.out_data});
            if (fd28) fd28_cnt++;
            if (fd8) fd8_cnt++;
        end
    end

    task automatic push4(input int p);
        int w;
        w = 0;
        a4.in_valid = 1'b1;
        a4.in_pixel = 8'(p);
        @(negedge clk);
        while (!a4.in_ready && w < 200) begin
            @(negedge clk);
            w++;
        end
        if (!a4.in_ready) check_eq("push4_timeout", 32'(a4.in_ready), 32'd1);
        @(posedge clk);
        #1;
        a4.in_valid = 1'b0;
    endtask

    task automatic push28(input int p);
        a28.in_valid = 1'b1;
        a28.in_pixel = 8'(p);
        @(negedge clk);
        if (!a28.in_ready) begin
            stall28++;
            check_eq("push28_ready", 32'(a28.in_ready), 32'd1);
        end
        @(posedge clk);
        #1;
        a28.in_valid = 1'b0;
    endtask

    task automatic push8(input int p);
        a8.in_valid = 1'b1;
        a8.in_pixel = 8'(p);
        @(negedge clk);
        if (!a8.in_ready) check_eq("push8_ready", 32'(a8.in_ready), 32'd1);
        @(posedge clk);
        #1;
        a8.in_valid = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic check_q4(input string tag, input int e0, input int e1, input int e2, input int e3);
        int exp_v[4];
        exp_v = '{e0, e1, e2, e3};
        check_eq({tag, "_count"}, 32'(q4.size()), 32'd4);
        for (int i = 0; i < 4; i++) begin
            if (i < q4.size()) begin
                check_eq({tag, "_data"}, 32'(q4[i][15:0]), 32'(exp_v[i]));
                check_eq({tag, "_last"}, 32'(q4[i][16]), (i == 3) ? 32'd1 : 32'd0);
            end
        end
        q4.delete();
    endtask

    initial begin
        int fd_before;
        int bad_v;
        int bad_l;
        logic [3:0] pat;
        pat = 4'b1001;
        reset_n = 1'b0;
        clear4 = 1'b0; clear28 = 1'b0; clear8 = 1'b0;
        a4.in_valid = 1'b0;  a4.in_pixel = 8'd0;  a4.out_ready = 1'b1;
        a28.in_valid = 1'b0; a28.in_pixel = 8'd0; a28.out_ready = 1'b1;
        a8.in_valid = 1'b0;  a8.in_pixel = 8'd0;  a8.out_ready = 1'b1;
`ifdef AVG_POOL_MAX_EN
        pool_max = 1'b0;
        pm_off   = 1'b0;
`endif
        idle(3);
        reset_n = 1'b1;
        @(negedge clk);
        check_eq("rst_in_ready", 32'(a4.in_ready), 32'd1);
        check_eq("rst_out_valid", 32'(a4.out_valid), 32'd0);
        check_eq("rst_out_data", 32'(a4.out_data), 32'd0);
        check_eq("rst_out_last", 32'(a4.out_last), 32'd0);
        check_eq("rst_frame_done", 32'(fd4), 32'd0);
        idle(1);

        // 4x4 ramp, free-flowing output
        fd_before = fd4_cnt;
        for (int p = 0; p < 16; p++) push4(p);
        idle(4);
        check_q4("ramp", 2, 4, 10, 12);
        check_eq("ramp_frame_done", 32'(fd4_cnt - fd_before), 32'd1);

        // 28x28 all 255
        fd_before = fd28_cnt;
        for (int p = 0; p < 784; p++) push28(255);
        idle(4);
        check_eq("full_count", 32'(q28.size()), 32'd196);
        bad_v = 0;
        bad_l = 0;
        for (int i = 0; i < q28.size(); i++) begin
            if (q28[i][15:0] != 16'd255) bad_v++;
            if (q28[i][16] != (i == 195)) bad_l++;
        end
        check_eq("full_values", 32'(bad_v), 32'd0);
        check_eq("full_last", 32'(bad_l), 32'd0);
        check_eq("full_bubbles", 32'(stall28), 32'd0);
        check_eq("full_frame_done", 32'(fd28_cnt - fd_before), 32'd1);

        // 4x4 ramp with out_ready stalls
        fork
            begin
                for (int p = 0; p < 16; p++) push4(p);
            end
            begin
                for (int k = 0; k < 80; k++) begin
                    a4.out_ready = pat[k % 4];
                    @(posedge clk);
                    #1;
                end
                a4.out_ready = 1'b1;
            end
        join
        idle(4);
        check_q4("bp", 2, 4, 10, 12);

        // POOL=4, alternating 0/255 columns
        fd_before = fd8_cnt;
        for (int r = 0; r < 8; r++)
            for (int c = 0; c < 8; c++) push8((c % 2 == 1) ? 255 : 0);
        idle(4);
        check_eq("p4_count", 32'(q8.size()), 32'd4);
        for (int i = 0; i < 4; i++) begin
            if (i < q8.size()) begin
                check_eq("p4_data", 32'(q8[i][15:0]), 32'd127);
                check_eq("p4_last", 32'(q8[i][16]), (i == 3) ? 32'd1 : 32'd0);
            end
        end
        check_eq("p4_frame_done", 32'(fd8_cnt - fd_before), 32'd1);

        // Reset mid-frame after 7 pixels
        for (int p = 0; p < 7; p++) push4(200);
        reset_n = 1'b0;
        idle(1);
        reset_n = 1'b1;
        q4.delete();
        idle(1);
        for (int p = 0; p < 16; p++) push4(p);
        idle(4);
        check_q4("rst", 2, 4, 10, 12);

        // Clear mid-frame, coinciding with a handshake whose pixel is dropped
        for (int p = 0; p < 3; p++) push4(77);
        clear4 = 1'b1;
        a4.in_valid = 1'b1;
        a4.in_pixel = 8'd99;
        idle(1);
        clear4 = 1'b0;
        a4.in_valid = 1'b0;
        q4.delete();
        for (int p = 0; p < 16; p++) push4(p);
        idle(4);
        check_q4("clr", 2, 4, 10, 12);

`ifdef AVG_POOL_MAX_EN
        pool_max = 1'b1;
        for (int p = 0; p < 16; p++) push4(p);
        idle(4);
        check_q4("max", 5, 7, 13, 15);
        pool_max = 1'b0;
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
